mouse_sequence_decoder: RTL and testbench
=========================================

Name: mouse_sequence_decoder

Overview:
- Parses an incoming terminal byte stream and extracts 4-byte mouse-event sequences: introducer 0x1E, modifier byte, X byte, Y byte.
- Emits decoded button, modifier and text-coordinate fields as a one-cycle event pulse.
- Forwards every byte that is not part of a sequence unchanged to a downstream byte consumer.
- Sits on the host-input side of the terminal, between the serial receive buffer and the character processor. It is the receiving end of the mouse-reporting format.

Parameters:
INTRODUCER, 8'h1E, byte that opens a mouse sequence
TIMEOUT_CYCLES, 1000000, idle cycles before a partial sequence is abandoned (used only with the optional feature)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high
in_byte  input  8  incoming stream byte
in_valid  input  1  in_byte valid this cycle
in_ready  output  1  decoder accepts in_byte this cycle
pass_byte  output  8  forwarded non-sequence byte
pass_valid  output  1  pass_byte valid, held until accepted
pass_ready  input  1  downstream accepts pass_byte
event_valid  output  1  one-cycle pulse, decoded event fields valid
button_left  output  1  modifier bit0
button_right  output  1  modifier bit1
button_middle  output  1  modifier bit2
mod_shift  output  1  modifier bit3
mod_ctrl  output  1  modifier bit4
mod_alt  output  1  modifier bit5
mod_meta  output  1  modifier bit6
x_text  output  7  X byte bits[6:0], column 0..127
y_text  output  6  Y byte bits[5:0], row 0..63
seq_error  output  1  one-cycle pulse, malformed or abandoned sequence

Behaviour:
Reset and handshake:
- Reset values: all outputs 0, state IDLE, pass_byte 0.
- Reset mid-sequence discards the partial sequence. No event and no error is emitted.
- A byte is accepted when in_valid && in_ready.
- in_ready = !pass_valid || pass_ready, so there is no input loss under backpressure.
- pass_valid is set in the cycle after an accepted forwarded byte. It clears on pass_ready unless a new forward is loaded in the same cycle.
- Event fields are registered and hold their value until the next event. event_valid has no backpressure.

States: IDLE, GOT_INTRO, GOT_MOD, GOT_X.
- IDLE, accepted byte == INTRODUCER -> GOT_INTRO. Any other byte is forwarded to pass_byte.
- GOT_INTRO, byte[7]==1 -> latch modifier, go to GOT_MOD.
- GOT_MOD, byte[7]==1 -> latch X, go to GOT_X.
- GOT_X, byte[7:6]==2'b10 -> latch Y, drive event_valid=1 and all fields in the next cycle, go to IDLE.
- Latency: event_valid asserts 1 cycle after the Y byte is accepted.

Malformed byte in GOT_INTRO, GOT_MOD or GOT_X (fails the check above):
- seq_error pulses 1 cycle after the byte is accepted.
- The partial sequence is dropped; its earlier bytes are not forwarded.
- The offending byte is then handled as in IDLE:
  - if it equals INTRODUCER -> GOT_INTRO (resynchronise);
  - otherwise it is forwarded and the state goes to IDLE.
- GOT_X receiving a byte with bit7=1 and bit6=1 counts as malformed. It is forwarded.

Simultaneous events and fields:
- A forward and an error pulse may occur in the same cycle.
- An event and a forward never coincide, because one byte is accepted per cycle.
- The top bits of the X and Y bytes are not reported. Field widths are fixed; no arithmetic is performed.

Optional Feature:
MOUSE_DECODER_TIMEOUT_EN
- Defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) increments each cycle while the state is not IDLE and no byte is accepted. It resets to 0 on every accepted byte.
  - When it reaches TIMEOUT_CYCLES: seq_error pulses, state -> IDLE, partial bytes are discarded.
  - The counter saturates and does not wrap.
- Undefined:
  - No counter is built.
  - A partial sequence waits indefinitely for its next byte.

Test Plan:
- Bytes 1E 85 8A 93 with pass_ready=1 -> one event_valid pulse 1 cycle after 0x93. Fields: left=1, middle=1, right=0, shift/ctrl/alt/meta=0, x_text=10, y_text=19. pass_valid stays 0.
- Bytes 41 1E F0 FF BF -> pass_byte=0x41 forwarded. Event: ctrl=1, alt=1, meta=1, buttons=0, x_text=127, y_text=63.
- Bytes 1E 81 41 -> seq_error pulse after 0x41, 0x41 forwarded, no event, state IDLE. A following 1E 80 80 80 decodes x_text=0, y_text=0.
- Bytes 1E 1E 82 85 86 -> seq_error at the second 0x1E, resync. Event: right=1, x_text=5, y_text=6.
- Hold pass_ready=0 after forwarding 0x41 -> in_ready=0, further bytes are stalled, pass_byte stays 0x41. Release pass_ready -> stream resumes with no loss.
- With MOUSE_DECODER_TIMEOUT_EN and TIMEOUT_CYCLES=16: send 1E 84, then idle 16 cycles -> seq_error pulse, state IDLE. A later 0x84 is forwarded, not decoded.

Source files
------------

// File: rtl/mouse_sequence_decoder.sv
// rtl/mouse_sequence_decoder.sv - splits 0x1E mouse-event sequences out of a terminal byte stream (optional idle timeout: MOUSE_DECODER_TIMEOUT_EN)
module mouse_sequence_decoder #(
  parameter logic [7:0]  INTRODUCER     = 8'h1E,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_byte,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] pass_byte,
  output logic       pass_valid,
  input  logic       pass_ready,
  output logic       event_valid,
  output logic       button_left,
  output logic       button_right,
  output logic       button_middle,
  output logic       mod_shift,
  output logic       mod_ctrl,
  output logic       mod_alt,
  output logic       mod_meta,
  output logic [6:0] x_text,
  output logic [5:0] y_text,
  output logic       seq_error
);

  typedef enum logic [1:0] {IDLE, GOT_INTRO, GOT_MOD, GOT_X} state_t;

  state_t     state, state_next;
  logic       accept;
  logic       byte_ok;
  logic       fwd_load, err_set, evt_set, mod_load, x_load;
  logic       timeout;
  logic [6:0] mod_q, x_q;

  // The forward register is the only thing that can stall the input.
  assign in_ready = !pass_valid || pass_ready;
  assign accept   = in_valid && in_ready;

`ifdef MOUSE_DECODER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] idle_cnt, idle_inc;

  assign idle_inc = (idle_cnt == CW'(TIMEOUT_CYCLES)) ? idle_cnt : idle_cnt + CW'(1);
  // The partial sequence is abandoned on the cycle the count reaches the limit.
  assign timeout  = (state != IDLE) && !accept && (idle_inc == CW'(TIMEOUT_CYCLES));

  // Saturating idle counter for an unfinished sequence, cleared by any accepted byte.
  always_ff @(posedge clk) begin
    if (reset || accept) idle_cnt <= '0;
    else if (state != IDLE) idle_cnt <= idle_inc;
  end
`else
  assign timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state and per-byte actions; a rejected byte is re-examined as if in IDLE.
  always_comb begin
    state_next = state;
    fwd_load   = 1'b0;
    err_set    = 1'b0;
    evt_set    = 1'b0;
    mod_load   = 1'b0;
    x_load     = 1'b0;
    byte_ok    = 1'b0;
    unique case (state)
      GOT_INTRO, GOT_MOD: byte_ok = in_byte[7];
      GOT_X:              byte_ok = (in_byte[7:6] == 2'b10);
      default:            byte_ok = 1'b0;
    endcase
    if (accept) begin
      if (state != IDLE && byte_ok) begin
        unique case (state)
          GOT_INTRO: begin mod_load = 1'b1; state_next = GOT_MOD; end
          GOT_MOD:   begin x_load = 1'b1;   state_next = GOT_X;   end
          default:   begin evt_set = 1'b1;  state_next = IDLE;    end
        endcase
      end else begin
        err_set = (state != IDLE);
        if (in_byte == INTRODUCER) begin
          state_next = GOT_INTRO;
        end else begin
          state_next = IDLE;
          fwd_load   = 1'b1;
        end
      end
    end else if (timeout) begin
      err_set    = 1'b1;
      state_next = IDLE;
    end
  end

  // Forward register, pulses and held event fields.
  always_ff @(posedge clk) begin
    if (reset) begin
      pass_byte     <= '0;
      pass_valid    <= 1'b0;
      event_valid   <= 1'b0;
      seq_error     <= 1'b0;
      mod_q         <= '0;
      x_q           <= '0;
      button_left   <= 1'b0;
      button_right  <= 1'b0;
      button_middle <= 1'b0;
      mod_shift     <= 1'b0;
      mod_ctrl      <= 1'b0;
      mod_alt       <= 1'b0;
      mod_meta      <= 1'b0;
      x_text        <= '0;
      y_text        <= '0;
    end else begin
      if (fwd_load) begin
        pass_byte  <= in_byte;
        pass_valid <= 1'b1;
      end else if (pass_ready) begin
        pass_valid <= 1'b0;
      end
      event_valid <= evt_set;
      seq_error   <= err_set;
      if (mod_load) mod_q <= in_byte[6:0];
      if (x_load)   x_q   <= in_byte[6:0];
      if (evt_set) begin
        {mod_meta, mod_alt, mod_ctrl, mod_shift,
         button_middle, button_right, button_left} <= mod_q;
        x_text <= x_q;
        y_text <= in_byte[5:0];
      end
    end
  end

endmodule

// File: tb/tb_mouse_sequence_decoder.sv
// tb/tb_mouse_sequence_decoder.sv - vector table, corner sequences and randomized model check for mouse_sequence_decoder
module tb_mouse_sequence_decoder;

  localparam int T = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_byte = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] pass_byte;
  logic       pass_valid;
  logic       pass_ready = 1'b1;
  logic       event_valid;
  logic       button_left, button_right, button_middle;
  logic       mod_shift, mod_ctrl, mod_alt, mod_meta;
  logic [6:0] x_text;
  logic [5:0] y_text;
  logic       seq_error;

  mouse_sequence_decoder #(.INTRODUCER(8'h1E), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset),
    .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
    .pass_byte(pass_byte), .pass_valid(pass_valid), .pass_ready(pass_ready),
    .event_valid(event_valid),
    .button_left(button_left), .button_right(button_right), .button_middle(button_middle),
    .mod_shift(mod_shift), .mod_ctrl(mod_ctrl), .mod_alt(mod_alt), .mod_meta(mod_meta),
    .x_text(x_text), .y_text(y_text), .seq_error(seq_error)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference: collected sequence bytes, forward register, pulses and held fields.
  logic [7:0]  m_seq[$];
  logic        m_pv, m_ev, m_er, m_ir;
  logic [7:0]  m_pb;
  logic [19:0] m_f;
  int          m_idle;

  typedef struct {
    logic [7:0]  b;
    logic        ev;
    logic        er;
    logic        pv;
    logic [7:0]  pb;
    logic [19:0] f;
  } vec_t;

  vec_t vecs[25];

  function automatic logic [19:0] fld(input logic [6:0] m, input logic [6:0] x, input logic [5:0] y);
    return {m, x, y};
  endfunction

  function automatic logic [19:0] dut_fields();
    return {mod_meta, mod_alt, mod_ctrl, mod_shift, button_middle, button_right, button_left, x_text, y_text};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_seq.delete();
    m_pv = 0; m_pb = '0; m_ev = 0; m_er = 0; m_f = '0; m_idle = 0;
  endtask

  task automatic model_edge(input logic [7:0] b, input logic v, input logic r);
    logic acc, fwd, ok;
    m_ir = !m_pv || r;
    acc = v && m_ir;
    fwd = 0; m_ev = 0; m_er = 0; ok = 0;
    if (acc) begin
      m_idle = 0;
      if (m_seq.size() == 0) ok = 0;
      else if (m_seq.size() < 3) ok = b[7];
      else ok = (b[7:6] == 2'b10);
      if (m_seq.size() != 0 && ok) begin
        m_seq.push_back(b);
        if (m_seq.size() == 4) begin
          m_ev = 1;
          m_f = fld(m_seq[1][6:0], m_seq[2][6:0], m_seq[3][5:0]);
          m_seq.delete();
        end
      end else begin
        if (m_seq.size() != 0) m_er = 1;
        m_seq.delete();
        if (b == 8'h1E) m_seq.push_back(b);
        else fwd = 1;
      end
    end
`ifdef MOUSE_DECODER_TIMEOUT_EN
    else if (m_seq.size() != 0) begin
      m_idle++;
      if (m_idle == T) begin
        m_er = 1;
        m_seq.delete();
      end
    end
`endif
    if (fwd) begin m_pv = 1; m_pb = b; end
    else if (r) m_pv = 0;
  endtask

  task automatic step(input logic [7:0] b, input logic v, input logic r);
    @(negedge clk);
    in_byte = b; in_valid = v; pass_ready = r;
    model_edge(b, v, r);
    #1;
    chk("in_ready", in_ready, m_ir);
    @(posedge clk);
    #1;
  endtask

  task automatic check_model();
    chk("event_valid", event_valid, m_ev);
    chk("seq_error", seq_error, m_er);
    chk("pass_valid", pass_valid, m_pv);
    chk("pass_byte", pass_byte, m_pb);
    chk("fields", dut_fields(), m_f);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1; in_valid = 0; pass_ready = 1;
    model_clear();
    @(posedge clk);
    #1;
    chk("rst_event", event_valid, 0);
    chk("rst_error", seq_error, 0);
    chk("rst_pass_valid", pass_valid, 0);
    chk("rst_pass_byte", pass_byte, 0);
    chk("rst_fields", dut_fields(), 0);
    @(negedge clk);
    reset = 0;
    #1;
    chk("rst_in_ready", in_ready, 1);
  endtask

  initial begin
    logic [19:0] f1, f2, f3, f4;
    logic [7:0]  b;
    int          sel;
    f1 = fld(7'h05, 7'h0A, 6'h13);
    f2 = fld(7'h70, 7'h7F, 6'h3F);
    f3 = fld(7'h00, 7'h00, 6'h00);
    f4 = fld(7'h02, 7'h05, 6'h06);
    vecs[0]  = '{8'h1E, 0, 0, 0, 8'h00, 20'h0};
    vecs[1]  = '{8'h85, 0, 0, 0, 8'h00, 20'h0};
    vecs[2]  = '{8'h8A, 0, 0, 0, 8'h00, 20'h0};
    vecs[3]  = '{8'h93, 1, 0, 0, 8'h00, f1};
    vecs[4]  = '{8'h41, 0, 0, 1, 8'h41, f1};
    vecs[5]  = '{8'h1E, 0, 0, 0, 8'h41, f1};
    vecs[6]  = '{8'hF0, 0, 0, 0, 8'h41, f1};
    vecs[7]  = '{8'hFF, 0, 0, 0, 8'h41, f1};
    vecs[8]  = '{8'hBF, 1, 0, 0, 8'h41, f2};
    vecs[9]  = '{8'h1E, 0, 0, 0, 8'h41, f2};
    vecs[10] = '{8'h81, 0, 0, 0, 8'h41, f2};
    vecs[11] = '{8'h41, 0, 1, 1, 8'h41, f2};
    vecs[12] = '{8'h1E, 0, 0, 0, 8'h41, f2};
    vecs[13] = '{8'h80, 0, 0, 0, 8'h41, f2};
    vecs[14] = '{8'h80, 0, 0, 0, 8'h41, f2};
    vecs[15] = '{8'h80, 1, 0, 0, 8'h41, f3};
    vecs[16] = '{8'h1E, 0, 0, 0, 8'h41, f3};
    vecs[17] = '{8'h1E, 0, 1, 0, 8'h41, f3};
    vecs[18] = '{8'h82, 0, 0, 0, 8'h41, f3};
    vecs[19] = '{8'h85, 0, 0, 0, 8'h41, f3};
    vecs[20] = '{8'h86, 1, 0, 0, 8'h41, f4};
    vecs[21] = '{8'h1E, 0, 0, 0, 8'h41, f4};
    vecs[22] = '{8'h80, 0, 0, 0, 8'h41, f4};
    vecs[23] = '{8'h80, 0, 0, 0, 8'h41, f4};
    vecs[24] = '{8'hC5, 0, 1, 1, 8'hC5, f4};

    model_clear();
    do_reset();

    for (int i = 0; i < 25; i++) begin
      step(vecs[i].b, 1, 1);
      chk("vec_event", event_valid, vecs[i].ev);
      chk("vec_error", seq_error, vecs[i].er);
      chk("vec_pass_valid", pass_valid, vecs[i].pv);
      chk("vec_pass_byte", pass_byte, vecs[i].pb);
      chk("vec_fields", dut_fields(), vecs[i].f);
      check_model();
    end
    step(8'h00, 0, 1);
    check_model();

    // Backpressure: the forward register holds and the input stalls without loss.
    step(8'h41, 1, 1);
    check_model();
    for (int i = 0; i < 3; i++) begin
      step(8'h42, 1, 0);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_pass_byte", pass_byte, 8'h41);
      chk("bp_pass_valid", pass_valid, 1);
      check_model();
    end
    step(8'h42, 1, 1);
    chk("bp_resume_byte", pass_byte, 8'h42);
    check_model();
    step(8'h43, 1, 1);
    chk("bp_next_byte", pass_byte, 8'h43);
    check_model();
    step(8'h00, 0, 1);
    check_model();

    // Reset in the middle of a sequence discards it silently.
    step(8'h1E, 1, 1);
    step(8'h81, 1, 1);
    do_reset();
    step(8'h8A, 1, 1);
    chk("midrst_error", seq_error, 0);
    chk("midrst_fwd", pass_byte, 8'h8A);
    check_model();

`ifdef MOUSE_DECODER_TIMEOUT_EN
    step(8'h1E, 1, 1);
    step(8'h84, 1, 1);
    for (int i = 1; i <= T; i++) begin
      step(8'h00, 0, 1);
      chk("to_error", seq_error, (i == T));
      check_model();
    end
    step(8'h84, 1, 1);
    chk("to_fwd_valid", pass_valid, 1);
    chk("to_fwd_byte", pass_byte, 8'h84);
    chk("to_no_event", event_valid, 0);
    check_model();
`endif

    // Randomized traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 3) b = 8'h1E;
      else if (sel < 8) b = 8'h80 | 8'($urandom_range(0, 127));
      else b = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 99) == 0) begin
        for (int k = 0; k < 20; k++) begin
          step(b, 0, 1);
          check_model();
        end
      end
      step(b, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
      check_model();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
